// File: rtl/jpeg_dequant.sv
// jpeg_dequant: JPEG coefficient dequantiser.
//   Parses DQT segment bytes into NUM_TABLES x 64 quantisation tables (zigzag
//   order), then multiplies each zigzag-order input coefficient by its table
//   entry and emits it with a natural-order (dezigzagged) index.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   img_start_i                  new image: flushes in-flight samples
//   img_dqt_table_{y,cb,cr}_i    table selector per colour component
//   cfg_valid_i/data_i/last_i    DQT byte stream; cfg_accept_o always 1
//   inport_*                     coefficient in (valid/accept), id[31:30] = component
//   outport_*                    dequantised coefficient out (valid/accept)
//
// Optional feature: define JPEG_DEQUANT_SAT_EN to saturate the product to the
// signed OUT_W range instead of wrapping.
module jpeg_dequant #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned NUM_TABLES = 4,
  localparam int unsigned TBL_W     = $clog2(NUM_TABLES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              img_start_i,
  input  logic [TBL_W-1:0]  img_dqt_table_y_i,
  input  logic [TBL_W-1:0]  img_dqt_table_cb_i,
  input  logic [TBL_W-1:0]  img_dqt_table_cr_i,
  input  logic              cfg_valid_i,
  input  logic [7:0]        cfg_data_i,
  input  logic              cfg_last_i,
  output logic              cfg_accept_o,
  input  logic              inport_valid_i,
  input  logic [DATA_W-1:0] inport_data_i,
  input  logic [5:0]        inport_idx_i,
  input  logic [31:0]       inport_id_i,
  input  logic              inport_eob_i,
  output logic              inport_accept_o,
  output logic              outport_valid_o,
  output logic [OUT_W-1:0]  outport_data_o,
  output logic [5:0]        outport_idx_o,
  output logic [31:0]       outport_id_o,
  output logic              outport_eob_o,
  input  logic              outport_accept_i
);

  localparam int unsigned ENT_W   = 16;
  localparam int unsigned ADDR_W  = TBL_W + 6;
  localparam int unsigned DEPTH   = NUM_TABLES * 64;
  // Signed data x unsigned 16-bit entry always fits in DATA_W + ENT_W + 1 bits.
  localparam int unsigned PROD_W  = DATA_W + ENT_W + 1;

  // Zigzag position -> natural (row-major) coefficient index.
  localparam logic [5:0] ZZ_TO_NAT [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [1:0] {
    ST_HDR    = 2'd0,
    ST_ENT_HI = 2'd1,
    ST_ENT_LO = 2'd2
  } parse_state_e;

  // ---------------------------------------------------------------------------
  // DQT parser
  // ---------------------------------------------------------------------------
  parse_state_e       state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [7:0]         hi_q, hi_d;
  logic [TBL_W-1:0]   tq_q, tq_d;
  logic               pq16_q, pq16_d;
  logic               drop_q, drop_d;
  logic               tbl_we_c;
  logic [ADDR_W-1:0]  tbl_waddr_c;
  logic [ENT_W-1:0]   tbl_wdata_c;

  assign cfg_accept_o = 1'b1;

  // Parser state and segment context registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_HDR;
      cnt_q   <= '0;
      hi_q    <= '0;
      tq_q    <= '0;
      pq16_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      tq_q    <= tq_d;
      pq16_q  <= pq16_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state and table write generation; every byte is accepted.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    tq_d        = tq_q;
    pq16_d      = pq16_q;
    drop_d      = drop_q;
    tbl_we_c    = 1'b0;
    tbl_waddr_c = {tq_q, cnt_q};
    tbl_wdata_c = pq16_q ? {hi_q, cfg_data_i} : {8'd0, cfg_data_i};
    if (cfg_valid_i) begin
      case (state_q)
        ST_HDR: begin
          tq_d    = cfg_data_i[TBL_W-1:0];
          pq16_d  = (cfg_data_i[7:4] == 4'd1);
          // Invalid precision or table id: still walk 64 entries, write none.
          drop_d  = (cfg_data_i[7:4] > 4'd1) ||
                    (5'(cfg_data_i[3:0]) >= 5'(NUM_TABLES));
          cnt_d   = '0;
          state_d = (cfg_data_i[7:4] == 4'd1) ? ST_ENT_HI : ST_ENT_LO;
        end
        ST_ENT_HI: begin
          hi_d    = cfg_data_i;
          state_d = ST_ENT_LO;
        end
        ST_ENT_LO: begin
          tbl_we_c = !drop_q;
          cnt_d    = cnt_q + 6'd1;
          if (cnt_q == 6'd63) begin
            state_d = ST_HDR;
          end else begin
            state_d = pq16_q ? ST_ENT_HI : ST_ENT_LO;
          end
        end
        default: state_d = ST_HDR;
      endcase
      if (cfg_last_i) begin
        state_d = ST_HDR;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Quantisation table storage (not reset)
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0] tbl_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (tbl_we_c) begin
      tbl_mem[tbl_waddr_c] <= tbl_wdata_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic s1_valid_q;
  logic s1_adv_c;
  logic s2_adv_c;
  logic in_xfer_c;

  assign s2_adv_c        = !outport_valid_o || outport_accept_i;
  assign s1_adv_c        = !s1_valid_q || s2_adv_c;
  assign inport_accept_o = s1_adv_c && !img_start_i;
  assign in_xfer_c       = inport_valid_i && inport_accept_o;

  // Component -> table selector; component 3 falls back to table 0.
  logic [TBL_W-1:0]  lk_sel_c;
  logic [ADDR_W-1:0] lk_addr_c;

  always_comb begin
    lk_sel_c = '0;
    case (inport_id_i[31:30])
      2'd0:    lk_sel_c = img_dqt_table_y_i;
      2'd1:    lk_sel_c = img_dqt_table_cb_i;
      2'd2:    lk_sel_c = img_dqt_table_cr_i;
      default: lk_sel_c = '0;
    endcase
    lk_addr_c = {lk_sel_c, inport_idx_i};
  end

  // ---------------------------------------------------------------------------
  // Stage 1: table lookup and sample capture
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] s1_data_q;
  logic [5:0]        s1_idx_q;
  logic [31:0]       s1_id_q;
  logic              s1_eob_q;
  logic [ENT_W-1:0]  s1_entry_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
    end else if (img_start_i) begin
      s1_valid_q <= 1'b0;
    end else if (s1_adv_c) begin
      s1_valid_q <= inport_valid_i;
    end
  end

  // Read of a location written this same edge returns the old entry.
  always_ff @(posedge clk_i) begin
    if (in_xfer_c) begin
      s1_data_q  <= inport_data_i;
      s1_idx_q   <= inport_idx_i;
      s1_id_q    <= inport_id_i;
      s1_eob_q   <= inport_eob_i;
      s1_entry_q <= tbl_mem[lk_addr_c];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: multiply, wrap or saturate, dezigzag
  // ---------------------------------------------------------------------------
  logic [PROD_W-1:0] op_a_c;
  logic [PROD_W-1:0] op_b_c;
  logic [PROD_W-1:0] prod_c;
  logic [OUT_W-1:0]  res_c;

  // Operands are extended to the full product width so an unsigned multiply
  // yields the exact two's-complement product.
  always_comb begin
    op_a_c = {{(PROD_W - DATA_W){s1_data_q[DATA_W-1]}}, s1_data_q};
    op_b_c = {{(PROD_W - ENT_W){1'b0}}, s1_entry_q};
    prod_c = op_a_c * op_b_c;
  end

`ifdef JPEG_DEQUANT_SAT_EN
  localparam int unsigned HI_W = PROD_W - OUT_W + 1;
  logic [HI_W-1:0] prod_hi_c;

  // In range when all bits from the OUT_W sign bit upward agree.
  always_comb begin
    prod_hi_c = prod_c[PROD_W-1:OUT_W-1];
    if ((prod_hi_c == '0) || (prod_hi_c == '1)) begin
      res_c = prod_c[OUT_W-1:0];
    end else if (prod_c[PROD_W-1]) begin
      res_c = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      res_c = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  always_comb begin
    res_c = prod_c[OUT_W-1:0];
  end
`endif

  // Output register; payload only moves on a real S1 -> S2 transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outport_valid_o <= 1'b0;
      outport_data_o  <= '0;
      outport_idx_o   <= '0;
      outport_id_o    <= '0;
      outport_eob_o   <= 1'b0;
    end else if (img_start_i) begin
      outport_valid_o <= 1'b0;
    end else if (s2_adv_c) begin
      outport_valid_o <= s1_valid_q;
      if (s1_valid_q) begin
        outport_data_o <= res_c;
        outport_idx_o  <= ZZ_TO_NAT[s1_idx_q];
        outport_id_o   <= s1_id_q;
        outport_eob_o  <= s1_eob_q;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_dequant.sv
// Self-checking bench for jpeg_dequant (DATA_W=16, OUT_W=16, NUM_TABLES=4).
module tb_jpeg_dequant;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned OUT_W      = 16;
  localparam int unsigned NUM_TABLES = 4;
  localparam int unsigned TBL_W      = 2;

`ifdef JPEG_DEQUANT_SAT_EN
  localparam logic [15:0] EXP_POS = 16'h7FFF;
  localparam logic [15:0] EXP_NEG = 16'h8000;
`else
  localparam logic [15:0] EXP_POS = 16'h0000;
  localparam logic [15:0] EXP_NEG = 16'h0000;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              img_start_i;
  logic [TBL_W-1:0]  img_dqt_table_y_i;
  logic [TBL_W-1:0]  img_dqt_table_cb_i;
  logic [TBL_W-1:0]  img_dqt_table_cr_i;
  logic              cfg_valid_i;
  logic [7:0]        cfg_data_i;
  logic              cfg_last_i;
  logic              cfg_accept_o;
  logic              inport_valid_i;
  logic [DATA_W-1:0] inport_data_i;
  logic [5:0]        inport_idx_i;
  logic [31:0]       inport_id_i;
  logic              inport_eob_i;
  logic              inport_accept_o;
  logic              outport_valid_o;
  logic [OUT_W-1:0]  outport_data_o;
  logic [5:0]        outport_idx_o;
  logic [31:0]       outport_id_o;
  logic              outport_eob_o;
  logic              outport_accept_i;

  jpeg_dequant #(
    .DATA_W    (DATA_W),
    .OUT_W     (OUT_W),
    .NUM_TABLES(NUM_TABLES)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .img_start_i       (img_start_i),
    .img_dqt_table_y_i (img_dqt_table_y_i),
    .img_dqt_table_cb_i(img_dqt_table_cb_i),
    .img_dqt_table_cr_i(img_dqt_table_cr_i),
    .cfg_valid_i       (cfg_valid_i),
    .cfg_data_i        (cfg_data_i),
    .cfg_last_i        (cfg_last_i),
    .cfg_accept_o      (cfg_accept_o),
    .inport_valid_i    (inport_valid_i),
    .inport_data_i     (inport_data_i),
    .inport_idx_i      (inport_idx_i),
    .inport_id_i       (inport_id_i),
    .inport_eob_i      (inport_eob_i),
    .inport_accept_o   (inport_accept_o),
    .outport_valid_o   (outport_valid_o),
    .outport_data_o    (outport_data_o),
    .outport_idx_o     (outport_idx_o),
    .outport_id_o      (outport_id_o),
    .outport_eob_o     (outport_eob_o),
    .outport_accept_i  (outport_accept_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] data;
    logic [5:0]  idx;
    logic [31:0] id;
    logic        eob;
  } exp_t;

  exp_t        sb_q [$];
  logic [15:0] ref_tbl [4][64];
  int          nat_of_zz [64];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_out = 0;
  bit          last_in_x;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Natural index of each zigzag position, built by walking the anti-diagonals.
  function automatic void build_zz();
    int r;
    int c;
    r = 0;
    c = 0;
    for (int k = 0; k < 64; k++) begin
      nat_of_zz[k] = r * 8 + c;
      if (((r + c) % 2) == 0) begin
        if (c == 7) r++;
        else if (r == 0) c++;
        else begin r--; c++; end
      end else begin
        if (r == 7) c++;
        else if (c == 0) r++;
        else begin r++; c--; end
      end
    end
  endfunction

  function automatic logic [15:0] exp_prod(input logic [15:0] d, input logic [15:0] e);
    longint ds;
    longint es;
    longint p;
    ds = longint'($signed(d));
    es = longint'(e);
    p  = ds * es;
`ifdef JPEG_DEQUANT_SAT_EN
    if (p > 32767) return 16'h7FFF;
    if (p < -32768) return 16'h8000;
`endif
    return 16'(p);
  endfunction

  function automatic int sel_of(input logic [1:0] comp);
    case (comp)
      2'd0:    return int'(img_dqt_table_y_i);
      2'd1:    return int'(img_dqt_table_cb_i);
      2'd2:    return int'(img_dqt_table_cr_i);
      default: return 0;
    endcase
  endfunction

  // One clock: sample handshakes away from the edge, score, advance to next negedge.
  task automatic step();
    exp_t e;
    bit   in_x;
    bit   out_x;
    #1;
    in_x  = inport_valid_i && inport_accept_o;
    out_x = outport_valid_o && outport_accept_i;
    if (out_x) begin
      n_out++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", longint'(outport_valid_o), 0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_data", longint'(outport_data_o), longint'(e.data));
        chk("sb_idx",  longint'(outport_idx_o),  longint'(e.idx));
        chk("sb_id",   longint'(outport_id_o),   longint'(e.id));
        chk("sb_eob",  longint'(outport_eob_o),  longint'(e.eob));
      end
    end
    if (in_x) begin
      e.data = exp_prod(inport_data_i, ref_tbl[sel_of(inport_id_i[31:30])][inport_idx_i]);
      e.idx  = 6'(nat_of_zz[inport_idx_i]);
      e.id   = inport_id_i;
      e.eob  = inport_eob_i;
      sb_q.push_back(e);
    end
    last_in_x = in_x;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic cfg_byte(input logic [7:0] b, input bit last);
    cfg_valid_i = 1'b1;
    cfg_data_i  = b;
    cfg_last_i  = last;
    step();
  endtask

  // One DQT table: header then 64 entries valued base + k*stp.
  task automatic dqt_seg(input int pq, input int tq, input int base, input int stp, input bit last);
    logic [15:0] v;
    cfg_byte(8'((pq << 4) | tq), 1'b0);
    for (int k = 0; k < 64; k++) begin
      v = 16'(base + k * stp);
      if (pq != 1) v = {8'd0, v[7:0]};
      if (pq == 1) cfg_byte(v[15:8], 1'b0);
      cfg_byte(v[7:0], last && (k == 63));
      if (tq < int'(NUM_TABLES) && pq <= 1) ref_tbl[tq][k] = v;
    end
    cfg_valid_i = 1'b0;
    cfg_last_i  = 1'b0;
  endtask

  // Single sample into an empty pipe: invisible after one edge, visible after two.
  task automatic lat_check(input string tag, input logic [15:0] d, input int zz,
                           input logic [1:0] comp, input logic [15:0] exp_d, input int exp_nat);
    inport_valid_i = 1'b1;
    inport_data_i  = d;
    inport_idx_i   = 6'(zz);
    inport_id_i    = {comp, 30'(zz * 7 + 1)};
    inport_eob_i   = (zz == 63);
    step();
    inport_valid_i = 1'b0;
    chk({tag, "_lat1"}, longint'(outport_valid_o), 0);
    step();
    chk({tag, "_valid"}, longint'(outport_valid_o), 1);
    chk({tag, "_data"}, longint'(outport_data_o), longint'(exp_d));
    chk({tag, "_idx"}, longint'(outport_idx_o), longint'(exp_nat));
    step();
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() > 0; i++) step();
    chk("drain_empty", longint'(sb_q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int cyc;
    int n0;
    build_zz();
    rst_i              = 1'b1;
    img_start_i        = 1'b0;
    img_dqt_table_y_i  = 2'd0;
    img_dqt_table_cb_i = 2'd1;
    img_dqt_table_cr_i = 2'd2;
    cfg_valid_i        = 1'b0;
    cfg_data_i         = '0;
    cfg_last_i         = 1'b0;
    inport_valid_i     = 1'b0;
    inport_data_i      = '0;
    inport_idx_i       = '0;
    inport_id_i        = '0;
    inport_eob_i       = 1'b0;
    outport_accept_i   = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Reset state
    chk("rst_valid", longint'(outport_valid_o), 0);
    chk("rst_data",  longint'(outport_data_o), 0);
    chk("rst_idx",   longint'(outport_idx_o), 0);
    chk("rst_id",    longint'(outport_id_o), 0);
    chk("rst_eob",   longint'(outport_eob_o), 0);
    chk("rst_cfg_acc", longint'(cfg_accept_o), 1);
    chk("rst_in_acc",  longint'(inport_accept_o), 1);

    // 8-bit table 0, all 2
    dqt_seg(0, 0, 2, 0, 1'b1);
    lat_check("t8", 16'd100, 2, 2'd0, 16'd200, 8);

    // 16-bit table 1, entry0 = 0x0100, selected by Cb
    dqt_seg(1, 1, 'h0100, 3, 1'b1);
    lat_check("t16", 16'd3, 0, 2'd1, 16'd768, 0);

    // Two tables in one segment, last only on the final byte
    dqt_seg(0, 0, 1, 1, 1'b0);
    dqt_seg(0, 2, 4, 0, 1'b1);
    lat_check("two_t0", 16'd1, 3, 2'd0, 16'd4, 16);
    lat_check("wrap_pos", 16'h4000, 5, 2'd2, EXP_POS, 2);
    lat_check("wrap_neg", 16'hC000, 63, 2'd2, EXP_NEG, 63);

    // Out-of-range table id leaves every table untouched
    dqt_seg(0, 5, 'hFF, 0, 1'b1);
    lat_check("tq5_t0", 16'd1, 3, 2'd0, 16'd4, 16);
    lat_check("tq5_t2", 16'd3, 10, 2'd2, 16'd12, 32);
    lat_check("tq5_t1", 16'd1, 5, 2'd1, 16'd271, 2);

    // 64-sample block with a 5-cycle downstream stall
    k   = 0;
    cyc = 0;
    n0  = n_out;
    while (k < 64 && cyc < 400) begin
      outport_accept_i = !(cyc >= 6 && cyc < 11);
      inport_valid_i   = 1'b1;
      inport_data_i    = 16'($urandom);
      inport_idx_i     = 6'(k);
      inport_id_i      = {2'b00, 30'(k)};
      inport_eob_i     = (k == 63);
      step();
      if (last_in_x) k++;
      cyc++;
    end
    chk("burst_in_all", longint'(k), 64);
    inport_valid_i   = 1'b0;
    outport_accept_i = 1'b1;
    drain(20);
    chk("burst_out_cnt", longint'(n_out - n0), 64);

    // Flush with two samples in flight behind a stalled output
    outport_accept_i = 1'b0;
    inport_valid_i   = 1'b1;
    inport_data_i    = 16'd5;
    inport_idx_i     = 6'd1;
    inport_id_i      = 32'h0000_00A1;
    inport_eob_i     = 1'b0;
    step();
    chk("fl_a_acc", longint'(last_in_x), 1);
    inport_data_i = 16'd6;
    inport_idx_i  = 6'd2;
    inport_id_i   = 32'h0000_00A2;
    step();
    chk("fl_b_acc", longint'(last_in_x), 1);
    inport_data_i = 16'd9;
    inport_idx_i  = 6'd3;
    img_start_i   = 1'b1;
    #1;
    chk("flush_in_acc", longint'(inport_accept_o), 0);
    step();
    img_start_i    = 1'b0;
    inport_valid_i = 1'b0;
    sb_q.delete();
    chk("flush_valid", longint'(outport_valid_o), 0);
    outport_accept_i = 1'b1;
    step();
    chk("flush_valid2", longint'(outport_valid_o), 0);
    lat_check("post_flush", 16'd7, 4, 2'd0, 16'd35, 9);

    drain(10);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
